// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: default sizes and a
// ceil-log2 helper usable in constant expressions.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;

    // Number of address bits needed to index 'value' entries.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, synchronous read into a
// reset-clearable output register that holds when no read is accepted.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEFAULT_DEPTH,
    localparam int unsigned AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with wrap-bit pointers, occupancy count,
// programmable almost-full/almost-empty levels and overflow/underflow pulses.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter  int unsigned AF_THRESH  = DEPTH - 2,
    parameter  int unsigned AE_THRESH  = 2,
    localparam int unsigned AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW     = AW + 1;
    localparam logic [AW:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [AW:0] AE_LVL = PW'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must be below DEPTH");
    end

    logic [AW:0] w_ptr_q, w_ptr_d;
    logic [AW:0] r_ptr_q, r_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_acc_c, rd_acc_c;

    // Flags depend only on registered state.
    assign full         = (w_ptr_q[AW] != r_ptr_q[AW]) && (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
    assign empty        = (w_ptr_q == r_ptr_q);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc_c = w_en && !full;
    assign rd_acc_c = r_en && !empty;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = w_en && full;
        underflow_d = r_en && empty;
        if (wr_acc_c) begin
            w_ptr_d = w_ptr_q + PW'(1);
        end
        if (rd_acc_c) begin
            r_ptr_d = r_ptr_q + PW'(1);
        end
        if (wr_acc_c && !rd_acc_c) begin
            count_d = count_q + PW'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (wr_acc_c),
        .waddr_i (w_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc_c),
        .raddr_i (r_ptr_q[AW-1:0]),
        .rdata_o (data_out)
    );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: a queue-based reference model predicts
// flags and read data; a separate monitor checks data on each read handshake.
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          w_en    = 1'b0;
    logic          r_en    = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]    count;

    param_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents as a queue, plus expected pulses and last read word.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;
    logic [DW-1:0] m_dout  = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    task automatic check_state();
        chk("count",        int'(count),        mq.size());
        chk("empty",        int'(empty),        int'(mq.size() == 0));
        chk("full",         int'(full),         int'(mq.size() == DEPTH));
        chk("almost_full",  int'(almost_full),  int'(mq.size() >= AF));
        chk("almost_empty", int'(almost_empty), int'(mq.size() <= AE));
        chk("overflow",     int'(overflow),     int'(exp_ovf));
        chk("underflow",    int'(underflow),    int'(exp_unf));
    endtask

    // Drive one cycle of requests (from a negedge), advance the model, check at next negedge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        logic wa, ra;
        w_en    = w;
        r_en    = r;
        data_in = d;
        wa      = w && (mq.size() != DEPTH);
        ra      = r && (mq.size() != 0);
        exp_ovf = w && (mq.size() == DEPTH);
        exp_unf = r && (mq.size() == 0);
        if (ra) begin
            exp_q.push_back(mq[0]);
            m_dout = mq[0];
            void'(mq.pop_front());
        end
        if (wa) mq.push_back(d);
        @(negedge clk);
        check_state();
    endtask

    // Monitor: a read handshake at a rising edge presents data at the next falling edge.
    logic          rd_hs = 1'b0;
    logic [DW-1:0] mon_exp;

    always @(posedge clk or negedge reset) begin
        if (!reset) rd_hs <= 1'b0;
        else        rd_hs <= r_en && !empty;
    end

    always @(negedge clk) begin
        if (rd_hs) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_data: got 0x%0h but no read was expected at %0t", data_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", int'(data_out), int'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] seq;
        int            wp, rp;

        // Reset and idle
        repeat (3) @(negedge clk);
        check_state();
        chk("reset_dout", int'(data_out), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0);
            chk("idle_dout", int'(data_out), 0);
        end

        // Fill to full, overflow attempt, drain in order
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

        // Underflow leaves data_out unchanged
        step(1'b0, 1'b1, '0);
        chk("underflow_dout_hold", int'(data_out), int'(m_dout));
        step(1'b0, 1'b0, '0);
        chk("idle_dout_hold", int'(data_out), 8'h10);

        // Steady state at count 8 with pointer wrap
        seq = 8'h20;
        for (int i = 0; i < 8; i++) begin step(1'b1, 1'b0, seq); seq++; end
        for (int i = 0; i < 40; i++) begin step(1'b1, 1'b1, seq); seq++; end

        // At full, simultaneous read and write: write dropped
        while (mq.size() < DEPTH) begin step(1'b1, 1'b0, seq); seq++; end
        step(1'b1, 1'b1, 8'hEE);
        chk("full_rw_count", int'(count), DEPTH - 1);

        // Randomized traffic with varying write/read bias
        for (int s = 0; s < 4; s++) begin
            wp = (s == 0) ? 70 : (s == 1) ? 30 : (s == 2) ? 50 : 90;
            rp = (s == 0) ? 30 : (s == 1) ? 70 : (s == 2) ? 50 : 90;
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), DW'($urandom));
            end
        end

        // Asynchronous reset mid-burst at count 5
        while (mq.size() > 5) step(1'b0, 1'b1, '0);
        while (mq.size() < 5) begin step(1'b1, 1'b0, seq); seq++; end
        w_en    = 1'b1;
        r_en    = 1'b1;
        data_in = 8'h77;
        #3;
        reset = 1'b0;
        #1;
        mq.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        m_dout  = '0;
        check_state();
        chk("async_reset_dout", int'(data_out), 0);
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        chk("post_reset_dout", int'(data_out), 8'hA5);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. Configurable width and depth; uses all DEPTH entries via wrap-bit pointers; adds occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses. Sits between a producer and a consumer in the same clock domain as the general-purpose buffering element.

## Interface
- DATA_WIDTH, 8, width of data_in/data_out
- DEPTH, 16, number of entries; power of two, ≥ 2
- AF_THRESH, DEPTH-2, almost_full asserted when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH
- Derived localparam AW = log2(DEPTH)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request
- data_out  out  DATA_WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write requested while full
- underflow  out  1  one-cycle pulse: read requested while empty

## Operation
- Reset (reset low, any time, asynchronous): w_ptr=0, r_ptr=0, count=0, data_out=0, overflow=0, underflow=0 → empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0). Storage array is not reset.
- Pointers are AW+1 bits; low AW bits address storage, MSB is wrap bit. Increment is modulo 2^(AW+1).
- full = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]); empty = (w_ptr == r_ptr). count is a dedicated register, must always equal w_ptr − r_ptr (mod 2^(AW+1)).
- Write accepted iff w_en && !full: mem[w_ptr[AW-1:0]] ← data_in, w_ptr += 1.
- Read accepted iff r_en && !empty: data_out ← mem[r_ptr[AW-1:0]], r_ptr += 1. Otherwise data_out holds.
- Accept decisions use flags at the start of the cycle. Write while full is dropped even if a read is accepted the same cycle; read while empty is rejected even if a write is accepted.
- Simultaneous accepted read and write: both pointers advance, count unchanged; read returns the old entry at r_ptr, never the word being written.
- count: +1 on write-only, −1 on read-only, unchanged on both or neither.
- overflow registered: 1 in cycle after w_en && full, else 0. underflow likewise for r_en && empty. Rejected requests change no other state.
- Flags full/empty/almost_* are combinational from registered pointers/count only (no input-to-output path).

## Timing
- Write-to-empty-deassert: 1 cycle (edge that accepts write).
- Read latency: data_out valid on the edge accepting the read; visible the following cycle.
- Fall-through not supported: first word requires an explicit r_en.
- Sustained throughput: one write and one read per cycle when 0 < count < DEPTH.
- Reset mid-operation: outputs take reset values asynchronously; first accepted op on the first rising edge after reset deasserts.

## Structure
- Shared package fifo_pkg: clog2 function, default DATA_WIDTH/DEPTH constants; reused by future FIFO variants.
- One sub-module: fifo_mem — simple dual-port array, DATA_WIDTH × DEPTH, synchronous write port, synchronous read port with read-enable feeding data_out register. Pointer/count/flag control stays in the top.
- Elaboration check: error if DEPTH not power of two, AF_THRESH > DEPTH, or AE_THRESH ≥ DEPTH.

## Test plan
- Reset then idle → empty=1, almost_empty=1, full=0, count=0, data_out=0x00 for 5 cycles.
- Defaults: write 0x01..0x10 (16 words) → full=1, count=16, almost_full from count 14; 17th write → overflow pulse 1 cycle, count stays 16; read 16 → data 0x01..0x10 in order, empty=1.
- Read while empty → underflow pulse 1 cycle, data_out unchanged, pointers unchanged.
- Fill to 8, then 40 cycles simultaneous w_en/r_en with incrementing data → count stays 8, output sequence continuous, pointers wrap past 2·DEPTH without corruption.
- At full, assert w_en and r_en together → read accepted, write dropped, overflow=1, count=15.
- Assert reset low mid-burst at count=5 (asynchronously, between edges) → all outputs to reset values immediately; after release, write 0xA5, read → 0xA5.
